// File: rtl/dm_port_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and an external loader/debug port.
// The CPU has fixed priority; EXT is forced through after STARVE_LIMIT consecutive denials.
module dm_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              dm_read,
  output logic              dm_write,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_in,
  input  logic [DATA_W-1:0] dm_out
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntMax  = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] CntLast = CntW'(STARVE_LIMIT - 1);

  typedef enum logic {StCpuPri, StExtForce} state_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnExt} owner_e;

  state_e            state_q, state_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] ext_rdata_q;

  logic cpu_req;
  logic cpu_win;
  logic ext_win;

  // Grant decision; everything is forced idle while reset is asserted.
  always_comb begin
    cpu_req = cpu_rd | cpu_wr;
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (!rst) begin
      if (state_q == StExtForce) begin
        ext_win = ext_req;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else begin
        ext_win = ext_req;
      end
    end
  end

  always_comb begin
    cpu_stall = ~rst & cpu_req & ~cpu_win;
    ext_gnt   = ext_win;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    dm_addr   = '0;
    dm_in     = '0;
    if (cpu_win) begin
      // A simultaneous read and write request resolves to the write.
      dm_write = cpu_wr;
      dm_read  = ~cpu_wr;
      dm_addr  = cpu_addr;
      dm_in    = cpu_wdata;
    end else if (ext_win) begin
      dm_write = ext_we;
      dm_read  = ~ext_we;
      dm_addr  = ext_addr;
      dm_in    = ext_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (ext_win || !ext_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < CntMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (state_q == StExtForce) begin
      state_d    = StCpuPri;
      wait_cnt_d = '0;
    end else if (ext_req && !ext_win && (wait_cnt_q == CntLast)) begin
      state_d = StExtForce;
    end

    if (cpu_win && !cpu_wr) begin
      rd_owner_d = OwnCpu;
    end else if (ext_win && !ext_we) begin
      rd_owner_d = OwnExt;
    end else begin
      rd_owner_d = OwnNone;
    end
  end

  // A return still in flight when reset hits is dropped rather than delivered.
  always_comb begin
    ext_rvalid = ~rst & (rd_owner_q == OwnExt);
    cpu_rdata  = (~rst && (rd_owner_q == OwnCpu)) ? dm_out : '0;
    ext_rdata  = ext_rvalid ? dm_out : ext_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCpuPri;
      wait_cnt_q  <= '0;
      rd_owner_q  <= OwnNone;
      ext_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
      if (ext_rvalid) begin
        ext_rdata_q <= dm_out;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: stimulus queues expected DM accesses and read returns,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        dm_read, dm_write;
  logic [15:0] dm_addr;
  logic [31:0] dm_in;
  logic [31:0] dm_out = 32'h0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic        gnt;
    logic        stall;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];
  logic [31:0] mem[0:255];

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_gnt   (ext_gnt),
    .ext_rvalid(ext_rvalid),
    .ext_rdata (ext_rdata),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_in     (dm_in),
    .dm_out    (dm_out)
  );

  // One-cycle-latency memory model.
  always @(posedge clk) begin
    if (dm_write === 1'b1) mem[dm_addr[7:0]] <= dm_in;
    if (dm_read === 1'b1) dm_out <= mem[dm_addr[7:0]];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected event at %0t", nm, $time);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  logic cpu_pend = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      cpu_pend = 1'b0;
    end else if (cpu_pend) begin
      cpu_pend = 1'b0;
      if (cpu_q.size() == 0) flag("cpu_rdata_extra");
      else chk("cpu_rdata", {96'h0, cpu_rdata}, {96'h0, cpu_q.pop_front()});
    end
    if (ext_rvalid === 1'b1) begin
      if (ext_q.size() == 0) flag("ext_rvalid_extra");
      else chk("ext_rdata", {96'h0, ext_rdata}, {96'h0, ext_q.pop_front()});
    end
    if (dm_read === 1'b1 || dm_write === 1'b1) begin
      if (acc_q.size() == 0) begin
        flag("dm_access_extra");
      end else begin
        acc_t e;
        e = acc_q.pop_front();
        chk("dm_we", {127'h0, dm_write}, {127'h0, e.we});
        chk("dm_rd", {127'h0, dm_read}, {127'h0, ~e.we});
        chk("dm_addr", {112'h0, dm_addr}, {112'h0, e.addr});
        if (e.we) chk("dm_in", {96'h0, dm_in}, {96'h0, e.data});
        chk("ext_gnt", {127'h0, ext_gnt}, {127'h0, e.gnt});
        chk("cpu_stall", {127'h0, cpu_stall}, {127'h0, e.stall});
        if (dm_read === 1'b1 && ext_gnt !== 1'b1 && rst === 1'b0) cpu_pend = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [15:0] a,
                         input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  task automatic exp_acc(input logic we, input logic [15:0] a, input logic [31:0] d,
                         input logic gnt, input logic stall);
    acc_t e;
    e.we = we; e.addr = a; e.data = d; e.gnt = gnt; e.stall = stall;
    acc_q.push_back(e);
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {ext_gnt, cpu_stall, dm_read, dm_write, dm_addr, dm_in, ext_rvalid, cpu_rdata,
             ext_rdata}, 128'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_cpu(0, 0, 16'h0, 32'h0);
    set_ext(0, 0, 16'h0, 32'h0);
    @(negedge clk);
    chk_idle("reset_outputs_0");
    @(negedge clk);
    chk_idle("reset_outputs_1");
    chk("reset_state", {127'h0, dut.state_q}, 128'h0);
    chk("reset_wait_cnt", {124'h0, dut.wait_cnt_q}, 128'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // CPU write then read back.
    set_cpu(0, 1, 16'h0010, 32'hDEADBEEF);
    exp_acc(1, 16'h0010, 32'hDEADBEEF, 0, 0);
    cyc();
    set_cpu(1, 0, 16'h0010, 32'h0);
    exp_acc(0, 16'h0010, 32'h0, 0, 0);
    cpu_q.push_back(32'hDEADBEEF);
    cyc();
    set_cpu(0, 0, 16'h0, 32'h0);
    cyc();

    // EXT-only read of the same word.
    set_ext(1, 0, 16'h0010, 32'h0);
    exp_acc(0, 16'h0010, 32'h0, 1, 0);
    ext_q.push_back(32'hDEADBEEF);
    cyc();
    set_ext(0, 0, 16'h0, 32'h0);
    cyc();
    cyc();

    // Starvation: EXT drops once (count restarts), then is forced on its 5th denied cycle.
    set_cpu(1, 0, 16'h0010, 32'h0);
    for (int i = 0; i < 7; i++) begin
      set_ext((i != 2), 1, 16'h0020, 32'h12345678);
      exp_acc(0, 16'h0010, 32'h0, 0, 0);
      cpu_q.push_back(32'hDEADBEEF);
      cyc();
    end
    set_ext(1, 1, 16'h0020, 32'h12345678);
    exp_acc(1, 16'h0020, 32'h12345678, 1, 1);
    cyc();
    set_ext(0, 0, 16'h0, 32'h0);
    exp_acc(0, 16'h0010, 32'h0, 0, 0);
    cpu_q.push_back(32'hDEADBEEF);
    cyc();
    set_cpu(0, 0, 16'h0, 32'h0);
    cyc();

    // Interleaved reads: CPU in N, EXT in N+1.
    set_cpu(1, 0, 16'h0010, 32'h0);
    exp_acc(0, 16'h0010, 32'h0, 0, 0);
    cpu_q.push_back(32'hDEADBEEF);
    cyc();
    set_cpu(0, 0, 16'h0, 32'h0);
    set_ext(1, 0, 16'h0020, 32'h0);
    exp_acc(0, 16'h0020, 32'h0, 1, 0);
    ext_q.push_back(32'h12345678);
    cyc();
    set_ext(0, 0, 16'h0, 32'h0);
    cyc();
    @(negedge clk);
    chk("ext_rdata_hold", {96'h0, ext_rdata}, {96'h0, 32'h12345678});
    cyc();

    // Read and write together: write wins.
    set_cpu(1, 1, 16'h0030, 32'hA5A50F0F);
    exp_acc(1, 16'h0030, 32'hA5A50F0F, 0, 0);
    cyc();
    set_cpu(1, 0, 16'h0030, 32'h0);
    exp_acc(0, 16'h0030, 32'h0, 0, 0);
    cpu_q.push_back(32'hA5A50F0F);
    cyc();
    set_cpu(0, 0, 16'h0, 32'h0);
    cyc();

    // Reset right after an EXT read grant discards the return.
    set_ext(1, 0, 16'h0010, 32'h0);
    exp_acc(0, 16'h0010, 32'h0, 1, 0);
    cyc();
    set_ext(0, 0, 16'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pending_rvalid", {127'h0, ext_rvalid}, 128'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pending_rvalid_after", {127'h0, ext_rvalid}, 128'h0);
    chk("rst_pending_wait_cnt", {124'h0, dut.wait_cnt_q}, 128'h0);
    cyc();
    cyc();
    cyc();

    chk("acc_q_drained", 128'(acc_q.size()), 128'h0);
    chk("cpu_q_drained", 128'(cpu_q.size()), 128'h0);
    chk("ext_q_drained", 128'(ext_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage and an external loader/debug port (EXT).
- Sits between CPU, loader and DM at top level; drives the DM read/write/address/data pins.
- The CPU has fixed priority. EXT gets a guaranteed grant once it has waited STARVE_LIMIT cycles.
- Tracks which requester owns the 1-cycle-latency read return and routes DM_out to that requester.

Parameters:
- ADDR_W, 16, DM word address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied EXT cycles before EXT is forced ahead of the CPU (legal range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_rd  in  1  CPU read request
- cpu_wr  in  1  CPU write request
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  CPU request denied this cycle; the CPU holds its request
- cpu_rdata  out  DATA_W  CPU load data
- ext_req  in  1  EXT access request, level, held until granted
- ext_we  in  1  EXT write (1) / read (0)
- ext_addr  in  ADDR_W  EXT address
- ext_wdata  in  DATA_W  EXT write data
- ext_gnt  out  1  1-cycle pulse: EXT access issued to DM this cycle
- ext_rvalid  out  1  EXT read data valid
- ext_rdata  out  DATA_W  EXT read data
- dm_read  out  1  DM read enable
- dm_write  out  1  DM write enable
- dm_addr  out  ADDR_W  DM address
- dm_in  out  DATA_W  DM write data
- dm_out  in  DATA_W  DM read data, valid the cycle after dm_read

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: wait_cnt=0, state=CPU_PRI, rd_owner=NONE, ext_rvalid=0.
- Combinational outputs under reset are forced to 0: ext_gnt, cpu_stall, dm_read, dm_write, dm_addr, dm_in.
- cpu_req = cpu_rd|cpu_wr. If cpu_rd and cpu_wr are both set, the write wins.
- Grant is combinational in the same cycle; at most one DM access per cycle.
- State CPU_PRI:
  - cpu_req → CPU granted.
  - else ext_req → EXT granted.
  - wait_cnt increments (saturating at STARVE_LIMIT) when ext_req=1 and EXT is not granted.
  - Go to EXT_FORCE when wait_cnt==STARVE_LIMIT-1 and EXT is denied again.
- State EXT_FORCE: EXT is granted unconditionally. cpu_stall = cpu_req. Next state is CPU_PRI and wait_cnt is cleared.
- Any EXT grant clears wait_cnt. Deasserting ext_req clears wait_cnt and does not change state.
- DM drive: the winner's address and data go to dm_addr/dm_in. dm_read=1 for a read grant, dm_write=1 for a write grant. With no grant, both enables are 0 and addr/data are 0.
- cpu_stall = cpu_req & ~cpu_granted. ext_gnt = ext_req & ext_granted.
- rd_owner register: set on a read grant to CPU or EXT, else NONE.
- Next-cycle return:
  - cpu_rdata = dm_out when rd_owner==CPU, else 0.
  - ext_rvalid=1 and ext_rdata=dm_out when rd_owner==EXT.
  - ext_rdata holds its last value otherwise.
- Back-to-back reads are fully pipelined: an issue in cycle N returns in N+1 while the next issue happens in N+1.
- Reset mid-operation: a pending read return is discarded (rd_owner=NONE) and no ext_rvalid is produced.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests. All outputs 0, dm_read=dm_write=0, state=CPU_PRI.
- CPU-only access: CPU write addr 0x0010 data 0xDEADBEEF, then CPU read 0x0010. Required response:
  - dm_write=1 in the write cycle.
  - cpu_rdata=0xDEADBEEF one cycle after the read grant.
  - cpu_stall=0 throughout.
- EXT-only read: ext_req=1, ext_we=0, addr 0x0010. Required response:
  - ext_gnt pulses the same cycle.
  - ext_rvalid=1 with ext_rdata=0xDEADBEEF in the next cycle, for 1 cycle.
- Starvation: cpu_rd held high continuously, ext_req=1 write 0x0020/0x12345678, STARVE_LIMIT=4. Required response:
  - EXT denied in cycles 0-3; EXT granted in cycle 4.
  - cpu_stall=1 only in cycle 4.
  - DM[0x20]=0x12345678.
  - CPU granted again in cycle 5.
- Interleaved reads: CPU read 0x10 in cycle N, EXT read 0x20 in N+1. Required response:
  - cpu_rdata=0xDEADBEEF at N+1.
  - ext_rdata=0x12345678 at N+2.
  - No cross-routing of data.
- Reset during pending EXT read: rst=1 in the cycle after the EXT grant. ext_rvalid stays 0 and wait_cnt=0.
